// File: rtl/mv_median_filter_p_if.sv
// Read-port and result-stream bundle of the motion-vector median filter.
// master = filter side, slave = memory/consumer side.
interface mv_median_filter_p_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic              rd_req;
  logic [2*AW-1:0]   rd_idx;
  logic              rd_ack;
  logic [DW:0]       rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_x;
  logic [AW-1:0]     out_y;
  logic [DW:0]       out_data;
  logic [2*AW-1:0]   out_idx;

  modport master (
    output rd_req, rd_idx, out_valid, out_x, out_y, out_data, out_idx,
    input  rd_ack, rd_data, out_ready
  );
  modport slave (
    input  rd_req, rd_idx, out_valid, out_x, out_y, out_data, out_idx,
    output rd_ack, rd_data, out_ready
  );
endinterface

// File: rtl/mv_median_filter_p.sv
// Raster-scan 3x3 median filter for motion vectors with NULL (bit DW) handling.
// Neighbours are fetched one at a time and insertion-sorted on capture.
module mv_median_filter_p #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic [1:0]           mode_i,
  input  logic [AW-1:0]        width_i,
  input  logic [AW-1:0]        height_i,
  output logic                 busy_o,
  output logic                 done_o,
  mv_median_filter_p_if.master bus
);
  localparam int IW = 2*AW;

  typedef enum logic [2:0] {S_IDLE, S_FETCH_C, S_FETCH_N, S_EMIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       x_q, x_d, y_q, y_d;
  logic [1:0]          mode_q, mode_d;
  logic [2:0]          nb_q, nb_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [8:0][DW-1:0]  buf_q, buf_d;
  logic [DW:0]         centre_q, centre_d;
  logic                rd_req_q, rd_req_d;
  logic [IW-1:0]       rd_idx_q, rd_idx_d;
  logic                out_valid_q, out_valid_d;
  logic [DW:0]         out_data_q, out_data_d;
  logic [AW-1:0]       out_x_q, out_x_d, out_y_q, out_y_d;
  logic [IW-1:0]       out_idx_q, out_idx_d;

  function automatic logic [IW-1:0] lin_idx(input logic [AW-1:0] xx, yy, ww);
    return (IW'(yy) - IW'(1)) * IW'(ww) + IW'(xx) - IW'(1);
  endfunction

  // neighbour offset decode: 0 = -1, 1 = 0, 2 = +1
  logic [1:0]    dx, dy;
  logic          nb_ok;
  logic [AW-1:0] nx, ny;
  always_comb begin
    case (nb_q)
      3'd0:    {dx, dy} = 4'b00_00;
      3'd1:    {dx, dy} = 4'b01_00;
      3'd2:    {dx, dy} = 4'b10_00;
      3'd3:    {dx, dy} = 4'b00_01;
      3'd4:    {dx, dy} = 4'b10_01;
      3'd5:    {dx, dy} = 4'b00_10;
      3'd6:    {dx, dy} = 4'b01_10;
      default: {dx, dy} = 4'b10_10;
    endcase
    nx = x_q;
    ny = y_q;
    nb_ok = 1'b1;
    if (dx == 2'd0) begin
      nx = x_q - AW'(1);
      nb_ok = nb_ok && (x_q > AW'(1));
    end else if (dx == 2'd2) begin
      nx = x_q + AW'(1);
      nb_ok = nb_ok && (x_q < width_i);
    end
    if (dy == 2'd0) begin
      ny = y_q - AW'(1);
      nb_ok = nb_ok && (y_q > AW'(1));
    end else if (dy == 2'd2) begin
      ny = y_q + AW'(1);
      nb_ok = nb_ok && (y_q < height_i);
    end
  end

  // Insert after all entries <= new value so equal keys keep arrival order.
  logic               ack, cap;
  logic [DW-1:0]      nv;
  logic [8:0]         keep;
  logic [8:0][DW-1:0] ins, nbuf;
  logic [3:0]         ncnt, midx;
  logic [DW:0]        med;
  assign ack = rd_req_q & bus.rd_ack;
  assign nv  = bus.rd_data[DW-1:0];
  always_comb begin
    for (int i = 0; i < 9; i++) keep[i] = (4'(i) < cnt_q) && (buf_q[i] <= nv);
    ins[0] = keep[0] ? buf_q[0] : nv;
    for (int i = 1; i < 9; i++) ins[i] = keep[i] ? buf_q[i] : (keep[i-1] ? nv : buf_q[i-1]);
    cap  = (state_q == S_FETCH_N) && ack && !bus.rd_data[DW];
    nbuf = cap ? ins : buf_q;
    ncnt = cnt_q + {3'b000, cap};
    midx = (ncnt - 4'd1) >> 1;
    med  = (ncnt == 4'd0) ? centre_q : {1'b0, nbuf[midx]};
  end

  always_comb begin
    logic [AW-1:0] px, py;
    px = x_q;
    py = y_q;
    state_d = state_q;
    x_d = x_q;  y_d = y_q;  mode_d = mode_q;  nb_d = nb_q;
    cnt_d = cnt_q;  buf_d = buf_q;  centre_d = centre_q;
    rd_req_d = rd_req_q;  rd_idx_d = rd_idx_q;
    out_valid_d = out_valid_q;  out_data_d = out_data_q;
    out_x_d = out_x_q;  out_y_d = out_y_q;  out_idx_d = out_idx_q;
    case (state_q)
      S_IDLE: if (enable_i) begin
        if (width_i == '0 || height_i == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH_C;
          x_d = AW'(1);
          y_d = AW'(1);
          mode_d = mode_i;
          rd_req_d = 1'b1;
          rd_idx_d = '0;
        end
      end
      S_FETCH_C: if (ack) begin
        rd_req_d = 1'b0;
        centre_d = bus.rd_data;
        out_x_d = x_q;
        out_y_d = y_q;
        out_idx_d = rd_idx_q;
        nb_d = 3'd0;
        cnt_d = 4'd0;
        if (bus.rd_data[DW] || mode_q == 2'd0) begin
          state_d = S_EMIT;
          out_valid_d = 1'b1;
          out_data_d = bus.rd_data;
        end else begin
          state_d = S_FETCH_N;
          if (mode_q == 2'd2) begin
            buf_d[0] = bus.rd_data[DW-1:0];
            cnt_d = 4'd1;
          end
        end
      end
      S_FETCH_N: begin
        if (rd_req_q) begin
          if (ack) begin
            rd_req_d = 1'b0;
            buf_d = nbuf;
            cnt_d = ncnt;
            if (nb_q == 3'd7) begin
              state_d = S_EMIT;
              out_valid_d = 1'b1;
              out_data_d = med;
            end else begin
              nb_d = nb_q + 3'd1;
            end
          end
        end else if (nb_ok) begin
          rd_req_d = 1'b1;
          rd_idx_d = lin_idx(nx, ny, width_i);
        end else if (nb_q == 3'd7) begin
          state_d = S_EMIT;
          out_valid_d = 1'b1;
          out_data_d = med;
        end else begin
          nb_d = nb_q + 3'd1;
        end
      end
      S_EMIT: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        // >= keeps the scan bounded even if width/height shrink mid-frame
        if (x_q >= width_i) begin
          px = AW'(1);
          py = y_q + AW'(1);
        end else begin
          px = x_q + AW'(1);
        end
        if (x_q >= width_i && y_q >= height_i) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH_C;
          x_d = px;
          y_d = py;
          rd_req_d = 1'b1;
          rd_idx_d = lin_idx(px, py, width_i);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q <= '0;  y_q <= '0;  mode_q <= '0;  nb_q <= '0;
      cnt_q <= '0;  buf_q <= '0;  centre_q <= '0;
      rd_req_q <= 1'b0;  rd_idx_q <= '0;
      out_valid_q <= 1'b0;  out_data_q <= '0;
      out_x_q <= '0;  out_y_q <= '0;  out_idx_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;  y_q <= y_d;  mode_q <= mode_d;  nb_q <= nb_d;
      cnt_q <= cnt_d;  buf_q <= buf_d;  centre_q <= centre_d;
      rd_req_q <= rd_req_d;  rd_idx_q <= rd_idx_d;
      out_valid_q <= out_valid_d;  out_data_q <= out_data_d;
      out_x_q <= out_x_d;  out_y_q <= out_y_d;  out_idx_q <= out_idx_d;
    end
  end

  assign bus.rd_req    = rd_req_q;
  assign bus.rd_idx    = rd_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_idx   = out_idx_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
endmodule

// File: tb/tb_mv_median_filter_p.sv
// Scoreboard bench for mv_median_filter_p: directed frames with hand-computed
// medians, a memory responder with variable ack delay, and a protocol monitor.
module tb_mv_median_filter_p;
  logic       CLK, reset, enable, busy, done;
  logic [1:0] mode;
  logic [7:0] width, height;

  mv_median_filter_p_if #(.DW(8), .AW(8)) bus ();

  mv_median_filter_p #(.DW(8), .AW(8)) dut (
    .CLK(CLK), .reset(reset), .enable_i(enable), .mode_i(mode),
    .width_i(width), .height_i(height), .busy_o(busy), .done_o(done), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  x, y;
    logic [15:0] idx;
    logic [8:0]  data;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] mem [256];
  int n_chk = 0, n_fail = 0;
  int rd_cnt = 0, done_cnt = 0;
  int ack_dly = 0, stall_left = 0;
  bit spurious = 0;

  logic [8:0] e_m1  [9] = '{9'd3, 9'd7, 9'd5, 9'd5, 9'd4, 9'd5, 9'd5, 9'd4, 9'd6};
  logic [8:0] e_m0  [9] = '{9'd9, 9'd1, 9'd7, 9'd3, 9'd5, 9'd8, 9'd2, 9'd6, 9'd4};
  logic [8:0] e_m2  [9] = '{9'd20, 9'd20, 9'h100, 9'd20, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
  logic [8:0] e_nul [9] = '{9'h1AB, 9'h042, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
  logic [8:0] e_none[9] = '{default: 9'd0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_3x3();
    logic [8:0] v [9] = '{9'd9, 9'd1, 9'd7, 9'd3, 9'd5, 9'd8, 9'd2, 9'd6, 9'd4};
    for (int i = 0; i < 9; i++) mem[i] = v[i];
  endtask

  // memory: acks after ack_dly waiting cycles; optional junk acks while idle
  initial begin : responder
    int w;
    w = 0;
    bus.rd_ack = 1'b0;
    bus.rd_data = '0;
    forever begin
      @(negedge CLK);
      if (!reset && bus.rd_req) begin
        if (w >= ack_dly) begin
          bus.rd_ack = 1'b1;
          bus.rd_data = mem[bus.rd_idx[7:0]];
          w = 0;
        end else begin
          bus.rd_ack = 1'b0;
          bus.rd_data = 9'h0AA;
          w++;
        end
      end else begin
        w = 0;
        bus.rd_ack = spurious && ($urandom_range(1, 0) == 1);
        bus.rd_data = 9'h0EE;
      end
    end
  end

  initial begin : ready_drv
    bus.out_ready = 1'b1;
    forever begin
      @(negedge CLK);
      if (bus.out_valid && stall_left > 0) begin
        bus.out_ready = 1'b0;
        stall_left--;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic pv, pr, pq, pa, pxf, pdn;
    logic [8:0] pd;
    logic [15:0] pi, pidx;
    exp_t e;
    pv = 0; pr = 0; pq = 0; pa = 0; pxf = 0; pdn = 0; pd = '0; pi = '0; pidx = '0;
    forever begin
      @(negedge CLK);
      #1;
      if (reset) begin
        pv = 0; pr = 0; pq = 0; pa = 0; pxf = 0; pdn = 0;
      end else begin
        if (pv && !pr) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, pd);
          chk("stall_idx", bus.out_idx, pi);
        end
        if (bus.out_valid) chk("no_rd_while_valid", bus.rd_req, 0);
        if (pxf) begin
          chk("valid_drop", bus.out_valid, 0);
          chk("next_fetch", bus.rd_req, !done);
        end
        if (pq && !pa) begin
          chk("rd_req_hold", bus.rd_req, 1);
          chk("rd_idx_hold", bus.rd_idx, pidx);
        end
        if (pq && pa) chk("rd_gap", bus.rd_req, 0);
        if (pdn) chk("done_pulse", done, 0);
        if (done) done_cnt++;
        if (bus.rd_req && bus.rd_ack) rd_cnt++;
        if (bus.out_valid && bus.out_ready) begin
          chk("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_idx", bus.out_idx, e.idx);
            chk("out_x", bus.out_x, e.x);
            chk("out_y", bus.out_y, e.y);
          end
        end
        pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pi = bus.out_idx;
        pq = bus.rd_req; pa = bus.rd_ack; pidx = bus.rd_idx;
        pxf = bus.out_valid && bus.out_ready; pdn = done;
      end
    end
  end

  task automatic run_frame(input string nm, input int w, input int h, input int md,
                           input int dly, input int stall, input bit spur,
                           input logic [8:0] ed [9], input int nrd);
    int r0, d0;
    bit ok;
    exp_t e;
    for (int k = 0; k < w*h; k++) begin
      e.x = 8'(k % w + 1);
      e.y = 8'(k / w + 1);
      e.idx = 16'(k);
      e.data = ed[k];
      sb.push_back(e);
    end
    @(negedge CLK);
    ack_dly = dly; stall_left = stall; spurious = spur;
    width = 8'(w); height = 8'(h); mode = 2'(md);
    r0 = rd_cnt; d0 = done_cnt;
    enable = 1'b1;
    @(negedge CLK);
    enable = 1'b0;
    ok = 0;
    for (int c = 0; c < 4000 && !ok; c++) begin
      @(negedge CLK);
      #2;
      ok = (done_cnt != d0);
    end
    chk({nm, "_done"}, ok, 1);
    @(negedge CLK);
    #2;
    chk({nm, "_reads"}, rd_cnt - r0, nrd);
    chk({nm, "_all_out"}, sb.size(), 0);
    sb.delete();
    spurious = 0;
  endtask

  initial begin : main
    int r0;
    bit ok;
    reset = 1'b1; enable = 1'b0; mode = 2'd0; width = 8'd0; height = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 9'h0CC;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_rd_req", bus.rd_req, 0);
    chk("rst_rd_idx", bus.rd_idx, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_x", bus.out_x, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge CLK);
    reset = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("idle_no_req", bus.rd_req, 0);

    load_3x3();
    run_frame("m1_3x3", 3, 3, 1, 0, 0, 0, e_m1, 49);
    run_frame("m3_slow_stall", 3, 3, 3, 3, 5, 1, e_m1, 49);
    run_frame("m0_3x3", 3, 3, 0, 1, 0, 0, e_m0, 9);
    run_frame("w0", 0, 3, 1, 0, 0, 0, e_none, 0);

    // reset while a neighbour read is outstanding
    @(negedge CLK);
    ack_dly = 3; width = 8'd3; height = 8'd3; mode = 2'd1;
    r0 = rd_cnt;
    enable = 1'b1;
    @(negedge CLK);
    enable = 1'b0;
    ok = 0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge CLK);
      #2;
      ok = (rd_cnt > r0) && bus.rd_req;
    end
    chk("rst_mid_reached", ok, 1);
    @(negedge CLK);
    reset = 1'b1;
    #1;
    chk("rst_mid_rd_req", bus.rd_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", bus.out_valid, 0);
    sb.delete();
    repeat (2) @(negedge CLK);
    reset = 1'b0;
    run_frame("restart_m1", 3, 3, 1, 0, 0, 0, e_m1, 49);

    mem[0] = 9'd10; mem[1] = 9'd20; mem[2] = 9'h100; mem[3] = 9'd30;
    run_frame("m2_2x2", 2, 2, 2, 0, 0, 0, e_m2, 13);
    mem[0] = 9'h1AB; mem[1] = 9'h042;
    run_frame("null_2x1", 2, 1, 1, 2, 0, 0, e_nul, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mv_median_filter_p.md
MV_MEDIAN_FILTER_P -- requirements
Module: mv_median_filter_p

Interface
REQ-001 Parameter DW, default 8: motion-vector value width; every data word is DW+1 bits, with bit DW as the NULL flag.
REQ-002 Parameter AW, default 8: coordinate width; the linear index is 2*AW bits.
REQ-003 CLK  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 enable  input  1  frame start request; sampled only in IDLE.
REQ-006 mode  input  2  0=bypass, 1=median of 8 neighbours, 2=median of 8 neighbours plus centre, 3=same as 1; sampled at frame start.
REQ-007 width, height  input  AW each  frame size in blocks; coordinates are 1-based.
REQ-008 rd_req  output  1  read request to vector memory.
REQ-009 rd_idx  output  2*AW  read address = (y-1)*width+(x-1), truncated to 2*AW bits.
REQ-010 rd_ack  input  1  read complete; rd_data is valid in the same cycle.
REQ-011 rd_data  input  DW+1  vector word read from memory.
REQ-012 out_valid  output  1  filtered result available.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 out_x, out_y  output  AW each  centre coordinate of the current result.
REQ-015 out_data  output  DW+1  filtered vector.
REQ-016 out_idx  output  2*AW  linear index of the centre.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at frame end.

Function
REQ-019 FSM states: IDLE, FETCH_C, FETCH_N, EMIT, DONE.
- IDLE->FETCH_C when enable=1, with x=1, y=1.
- IDLE->DONE directly when width=0 or height=0.
REQ-020 Scan is raster order: x runs 1..width, then x=1 and y increments; after (width,height) is emitted the FSM goes EMIT->DONE->IDLE.
REQ-021 Read handshake:
- rd_req and rd_idx are held stable until rd_ack=1.
- rd_data is captured in the rd_ack cycle.
- rd_req is 0 in the cycle after each ack.
- rd_ack while rd_req=0 is ignored.
REQ-022 FETCH_C reads the centre word. Go to EMIT with out_data = centre word when any of these holds:
- centre NULL (bit DW = 1);
- mode=0.
Otherwise go to FETCH_N.
REQ-023 FETCH_N visits neighbours in this order: (-1,-1), (0,-1), (+1,-1), (-1,0), (+1,0), (-1,+1), (0,+1), (+1,+1).
- Positions with coordinate <1, x>width or y>height are skipped with no read and cost at most one cycle each.
REQ-024 Each valid (non-NULL) neighbour value is inserted into an ascending sorted buffer of depth 9 in its capture cycle; NULL words are discarded. Mode 2 pre-inserts the centre value.
REQ-025 Let N = number of valid entries. Result = sorted entry at index floor((N-1)/2), i.e. the lower median, with the NULL bit = 0. If N=0, result = centre word.
REQ-026 Comparisons are unsigned on bits DW-1:0; ties keep insertion order.
REQ-027 out_valid rises exactly one cycle after the last rd_ack of the pixel, or one cycle after the last skip.
REQ-028 out_x, out_y, out_idx and out_data are stable while out_valid=1 and out_ready=0.
REQ-029 The transfer occurs when out_valid and out_ready are both 1; out_valid falls the next cycle and the next centre fetch starts that same cycle.
REQ-030 done is asserted for one cycle in DONE; enable=1 during DONE or in non-IDLE states is ignored.
REQ-031 width, height and mode changes mid-frame have undefined effect on results, but the FSM shall still terminate.

Reset
REQ-032 reset=1 forces IDLE immediately, including mid-read or mid-emit, and clears all sort buffer entries.
REQ-033 Reset values: rd_req=0, rd_idx=0, out_valid=0, out_x=0, out_y=0, out_data=0, out_idx=0, busy=0, done=0.
REQ-034 After reset deasserts, no rd_req is issued until enable is sampled high in IDLE.

Verification
REQ-035 3x3 frame, mode 1, centre (2,2)=5, neighbours 9,1,7,3,8,2,6,4, ack same cycle -> out_data=4 (sorted 1..9 minus 5, index 3), out_idx=4.
REQ-036 Corner (1,1), mode 2, centre=10, neighbours (2,1)=20, (1,2)=NULL, (2,2)=30 -> only 3 reads issued, N=3, out_data=20.
REQ-037 Centre NULL (0x1xx) in mode 1 -> no neighbour reads, out_data=centre word; mode 0 on any pixel -> out_data=centre after 1 read.
REQ-038 out_ready held 0 for 5 cycles -> out_valid, out_data and out_idx are constant; no rd_req until 1 cycle after acceptance.
REQ-039 rd_ack delayed 3 cycles -> rd_idx is stable for 4 cycles; width=0 -> done pulses with no rd_req; 2x2 frame -> exactly 4 results then done.
REQ-040 reset pulsed while rd_req=1 in FETCH_N -> next cycle rd_req=0, busy=0, out_valid=0; new enable restarts at (1,1).
